// File: rtl/rvfi_retire_serializer_if.sv
// Bundle of the NRET-wide RVFI retire input, the single-channel output and status.
// slave = serializer side, master = producer/consumer side.
interface rvfi_retire_serializer_if #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    logic [NRET-1:0]        in_valid;
    logic [NRET*8-1:0]      in_order;
    logic [NRET*32-1:0]     in_insn;
    logic [NRET-1:0]        in_trap;
    logic [NRET*5-1:0]      in_rs1_addr;
    logic [NRET*5-1:0]      in_rs2_addr;
    logic [NRET*5-1:0]      in_rd_addr;
    logic [NRET*XLEN-1:0]   in_rs1_rdata;
    logic [NRET*XLEN-1:0]   in_rs2_rdata;
    logic [NRET*XLEN-1:0]   in_rd_wdata;
    logic [NRET*XLEN-1:0]   in_pc_rdata;
    logic [NRET*XLEN-1:0]   in_pc_wdata;
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
    logic [NRET*XLEN-1:0]   in_mem_addr;
    logic [NRET*XLEN/8-1:0] in_mem_rmask;
    logic [NRET*XLEN/8-1:0] in_mem_wmask;
    logic [NRET*XLEN-1:0]   in_mem_rdata;
    logic [NRET*XLEN-1:0]   in_mem_wdata;
    logic [XLEN-1:0]        out_mem_addr;
    logic [XLEN/8-1:0]      out_mem_rmask;
    logic [XLEN/8-1:0]      out_mem_wmask;
    logic [XLEN-1:0]        out_mem_rdata;
    logic [XLEN-1:0]        out_mem_wdata;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_order;
    logic [31:0]            out_insn;
    logic                   out_trap;
    logic [4:0]             out_rs1_addr;
    logic [4:0]             out_rs2_addr;
    logic [4:0]             out_rd_addr;
    logic [XLEN-1:0]        out_rs1_rdata;
    logic [XLEN-1:0]        out_rs2_rdata;
    logic [XLEN-1:0]        out_rd_wdata;
    logic [XLEN-1:0]        out_pc_rdata;
    logic [XLEN-1:0]        out_pc_wdata;
    logic                   overflow;
    logic                   order_error;
    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  in_valid, in_order, in_insn, in_trap, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_rs1_rdata, in_rs2_rdata, in_rd_wdata, in_pc_rdata, in_pc_wdata,
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
               in_mem_addr, in_mem_rmask, in_mem_wmask, in_mem_rdata, in_mem_wdata,
        output out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata,
`endif
        input  out_ready,
        output out_valid, out_order, out_insn, out_trap, out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_rs1_rdata, out_rs2_rdata, out_rd_wdata, out_pc_rdata, out_pc_wdata,
               overflow, order_error, count
    );

    modport master (
        output in_valid, in_order, in_insn, in_trap, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_rs1_rdata, in_rs2_rdata, in_rd_wdata, in_pc_rdata, in_pc_wdata,
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
               in_mem_addr, in_mem_rmask, in_mem_wmask, in_mem_rdata, in_mem_wdata,
        input  out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata,
`endif
        output out_ready,
        input  out_valid, out_order, out_insn, out_trap, out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_rs1_rdata, out_rs2_rdata, out_rd_wdata, out_pc_rdata, out_pc_wdata,
               overflow, order_error, count
    );
endinterface

// File: rtl/rvfi_retire_serializer.sv
// Purpose: serialize an NRET-wide RVFI retire bundle into one RVFI channel, oldest first; memory fields when RVFI_RETIRE_SERIALIZER_MEM_EN is defined.
// Latency: one cycle from push to out_* when empty; no combinational in->out path.
// Backpressure: out_valid/out_ready; a cycle that does not fit is dropped whole and sets sticky overflow.
module rvfi_retire_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    rvfi_retire_serializer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0]        order;
        logic [31:0]       insn;
        logic              trap;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
`endif
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          ch_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
    logic [CW-1:0]   count_q, count_d, npush;
    logic [CW:0]     need;
    logic            overflow_q, overflow_d;
    logic            order_error_q, order_error_d;
    logic            expect_valid_q, expect_valid_d;
    logic [7:0]      expect_order_q, expect_order_d;
    logic            pop, accept;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        npush = '0;
        for (int ch = 0; ch < NRET; ch++) begin
            npush = npush + CW'(bus.in_valid[ch]);
        end
        pop    = (count_q != '0) && bus.out_ready;
        // Space freed by a same-cycle pop counts toward the push.
        need   = {1'b0, count_q} + {1'b0, npush} - (CW+1)'(pop);
        accept = (need <= (CW+1)'(DEPTH));

        mem_d    = mem_q;
        wr_idx   = wr_ptr_q;
        ch_entry = '0;
        for (int ch = 0; ch < NRET; ch++) begin
            ch_entry.order     = bus.in_order[ch*8 +: 8];
            ch_entry.insn      = bus.in_insn[ch*32 +: 32];
            ch_entry.trap      = bus.in_trap[ch];
            ch_entry.rs1_addr  = bus.in_rs1_addr[ch*5 +: 5];
            ch_entry.rs2_addr  = bus.in_rs2_addr[ch*5 +: 5];
            ch_entry.rd_addr   = bus.in_rd_addr[ch*5 +: 5];
            ch_entry.rs1_rdata = bus.in_rs1_rdata[ch*XLEN +: XLEN];
            ch_entry.rs2_rdata = bus.in_rs2_rdata[ch*XLEN +: XLEN];
            ch_entry.rd_wdata  = bus.in_rd_wdata[ch*XLEN +: XLEN];
            ch_entry.pc_rdata  = bus.in_pc_rdata[ch*XLEN +: XLEN];
            ch_entry.pc_wdata  = bus.in_pc_wdata[ch*XLEN +: XLEN];
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
            ch_entry.mem_addr  = bus.in_mem_addr[ch*XLEN +: XLEN];
            ch_entry.mem_rmask = bus.in_mem_rmask[ch*(XLEN/8) +: XLEN/8];
            ch_entry.mem_wmask = bus.in_mem_wmask[ch*(XLEN/8) +: XLEN/8];
            ch_entry.mem_rdata = bus.in_mem_rdata[ch*XLEN +: XLEN];
            ch_entry.mem_wdata = bus.in_mem_wdata[ch*XLEN +: XLEN];
`endif
            // Compacting write: only valid channels consume a slot.
            if (accept && bus.in_valid[ch]) begin
                mem_d[wr_idx] = ch_entry;
                wr_idx        = wr_idx + PW'(1);
            end
        end

        wr_ptr_d   = wr_idx;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + (accept ? npush : '0) - CW'(pop);
        overflow_d = overflow_q | ~accept;

        order_error_d  = order_error_q;
        expect_order_d = expect_order_q;
        expect_valid_d = expect_valid_q;
        if (pop) begin
            if (expect_valid_q && (head.order != expect_order_q)) begin
                order_error_d = 1'b1;
            end
            expect_order_d = head.order + 8'd1;
            expect_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            order_error_q  <= 1'b0;
            expect_valid_q <= 1'b0;
            expect_order_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            order_error_q  <= order_error_d;
            expect_valid_q <= expect_valid_d;
            expect_order_q <= expect_order_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid     = (count_q != '0);
    assign bus.out_order     = head.order;
    assign bus.out_insn      = head.insn;
    assign bus.out_trap      = head.trap;
    assign bus.out_rs1_addr  = head.rs1_addr;
    assign bus.out_rs2_addr  = head.rs2_addr;
    assign bus.out_rd_addr   = head.rd_addr;
    assign bus.out_rs1_rdata = head.rs1_rdata;
    assign bus.out_rs2_rdata = head.rs2_rdata;
    assign bus.out_rd_wdata  = head.rd_wdata;
    assign bus.out_pc_rdata  = head.pc_rdata;
    assign bus.out_pc_wdata  = head.pc_wdata;
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
    assign bus.out_mem_addr  = head.mem_addr;
    assign bus.out_mem_rmask = head.mem_rmask;
    assign bus.out_mem_wmask = head.mem_wmask;
    assign bus.out_mem_rdata = head.mem_rdata;
    assign bus.out_mem_wdata = head.mem_wdata;
`endif
    assign bus.overflow      = overflow_q;
    assign bus.order_error   = order_error_q;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed bench for rvfi_retire_serializer (NRET=2, XLEN=32, DEPTH=8).
module tb_rvfi_retire_serializer;
    localparam int NRET = 2, XLEN = 32, DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    rvfi_retire_serializer_if #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] insn_of(input logic [7:0] o);
        return {24'hC0FFEE, o};
    endfunction

    function automatic logic [31:0] rs1_of(input logic [7:0] o);
        return {8'h5A, o, 8'hA5, ~o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid = '0; bus.in_order = '0; bus.in_insn = '0; bus.in_trap = '0;
        bus.in_rs1_addr = '0; bus.in_rs2_addr = '0; bus.in_rd_addr = '0;
        bus.in_rs1_rdata = '0; bus.in_rs2_rdata = '0; bus.in_rd_wdata = '0;
        bus.in_pc_rdata = '0; bus.in_pc_wdata = '0;
`ifdef RVFI_RETIRE_SERIALIZER_MEM_EN
        bus.in_mem_addr = '0; bus.in_mem_rmask = '0; bus.in_mem_wmask = '0;
        bus.in_mem_rdata = '0; bus.in_mem_wdata = '0;
`endif
    endtask

    task automatic set_ch(input int ch, input logic [7:0] o);
        bus.in_valid[ch]                = 1'b1;
        bus.in_order[ch*8 +: 8]         = o;
        bus.in_insn[ch*32 +: 32]        = insn_of(o);
        bus.in_rd_addr[ch*5 +: 5]       = o[4:0];
        bus.in_rs1_rdata[ch*XLEN +: XLEN] = rs1_of(o);
        bus.in_pc_rdata[ch*XLEN +: XLEN]  = {22'd0, o, 2'b00};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.out_ready = 1'b0;
        clear_in();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fill_pairs(input logic [7:0] base, input int npairs);
        for (int i = 0; i < npairs; i++) begin
            clear_in();
            set_ch(0, base + 8'(2*i));
            set_ch(1, base + 8'(2*i + 1));
            step();
        end
        clear_in();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        clear_in();
        set_ch(0, 8'd40);
        set_ch(1, 8'd41);
        step();
        step();
        reset = 1'b0;
        clear_in();
        nvec++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", bus.count); end
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        nvec++; if (bus.order_error !== 1'b0) begin nerr++; $display("FAIL reset_order_error got %b want 0", bus.order_error); end
        step();
        nvec++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL reset_no_capture count got %0d want 0", bus.count); end
    endtask

    task automatic test_single_push();
        do_reset();
        bus.out_ready = 1'b1;
        set_ch(0, 8'd5);
        step();
        clear_in();
        nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        nvec++; if (bus.out_order !== 8'd5) begin nerr++; $display("FAIL single_order got %0d want 5", bus.out_order); end
        nvec++; if (bus.out_insn !== 32'hC0FFEE05) begin nerr++; $display("FAIL single_insn got %h want c0ffee05", bus.out_insn); end
        nvec++; if (bus.count !== 4'd1) begin nerr++; $display("FAIL single_count got %0d want 1", bus.count); end
        step();
        nvec++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin nerr++; $display("FAIL single_drained count %0d valid %b want 0 0", bus.count, bus.out_valid); end
        nvec++; if (bus.overflow !== 1'b0 || bus.order_error !== 1'b0) begin nerr++; $display("FAIL single_flags ovf %b oerr %b want 0 0", bus.overflow, bus.order_error); end
    endtask

    task automatic test_dual_retire();
        do_reset();
        bus.out_ready = 1'b1;
        set_ch(0, 8'd10);
        set_ch(1, 8'd11);
        step();
        clear_in();
        nvec++; if (bus.out_order !== 8'd10 || bus.count !== 4'd2) begin nerr++; $display("FAIL dual_first order %0d count %0d want 10 2", bus.out_order, bus.count); end
        nvec++; if (bus.out_rs1_rdata !== 32'h5A0AA5F5) begin nerr++; $display("FAIL dual_rs1 got %h want 5a0aa5f5", bus.out_rs1_rdata); end
        step();
        nvec++; if (bus.out_order !== 8'd11 || bus.count !== 4'd1) begin nerr++; $display("FAIL dual_second order %0d count %0d want 11 1", bus.out_order, bus.count); end
        nvec++; if (bus.out_pc_rdata !== 32'd44) begin nerr++; $display("FAIL dual_pc got %0d want 44", bus.out_pc_rdata); end
        step();
        nvec++; if (bus.count !== 4'd0 || bus.order_error !== 1'b0) begin nerr++; $display("FAIL dual_end count %0d oerr %b want 0 0", bus.count, bus.order_error); end
    endtask

    task automatic test_gap_compaction();
        do_reset();
        set_ch(1, 8'd3);
        step();
        clear_in();
        nvec++; if (bus.count !== 4'd1) begin nerr++; $display("FAIL gap_count got %0d want 1", bus.count); end
        nvec++; if (bus.out_order !== 8'd3 || bus.out_rd_addr !== 5'd3) begin nerr++; $display("FAIL gap_entry order %0d rd %0d want 3 3", bus.out_order, bus.out_rd_addr); end
        bus.out_ready = 1'b1;
        step();
        nvec++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL gap_drain count got %0d want 0", bus.count); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill_pairs(8'd0, 4);
        nvec++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin nerr++; $display("FAIL ovf_full count %0d ovf %b want 8 0", bus.count, bus.overflow); end
        fill_pairs(8'd8, 1);
        nvec++; if (bus.count !== 4'd8 || bus.overflow !== 1'b1) begin nerr++; $display("FAIL ovf_drop count %0d ovf %b want 8 1", bus.count, bus.overflow); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nvec++; if (bus.out_order !== 8'(i)) begin nerr++; $display("FAIL ovf_drain[%0d] got %0d want %0d", i, bus.out_order, i); end
            step();
        end
        nvec++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin nerr++; $display("FAIL ovf_empty count %0d valid %b want 0 0", bus.count, bus.out_valid); end
        nvec++; if (bus.overflow !== 1'b1 || bus.order_error !== 1'b0) begin nerr++; $display("FAIL ovf_sticky ovf %b oerr %b want 1 0", bus.overflow, bus.order_error); end
    endtask

    task automatic test_pop_at_full();
        do_reset();
        fill_pairs(8'd0, 4);
        bus.out_ready = 1'b1;
        set_ch(0, 8'd8);
        step();
        clear_in();
        nvec++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin nerr++; $display("FAIL popfull count %0d ovf %b want 8 0", bus.count, bus.overflow); end
        for (int i = 1; i <= 8; i++) begin
            nvec++; if (bus.out_order !== 8'(i)) begin nerr++; $display("FAIL popfull_drain[%0d] got %0d want %0d", i, bus.out_order, i); end
            step();
        end
        nvec++; if (bus.count !== 4'd0 || bus.order_error !== 1'b0) begin nerr++; $display("FAIL popfull_end count %0d oerr %b want 0 0", bus.count, bus.order_error); end
    endtask

    task automatic test_order_wrap();
        logic [3:0] want_err;
        want_err = 4'b1000;
        do_reset();
        set_ch(0, 8'd254);
        set_ch(1, 8'd255);
        step();
        clear_in();
        set_ch(0, 8'd0);
        set_ch(1, 8'd2);
        step();
        clear_in();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++; if (bus.order_error !== want_err[i]) begin nerr++; $display("FAIL wrap_pop[%0d] oerr got %b want %b", i, bus.order_error, want_err[i]); end
        end
        step();
        nvec++; if (bus.order_error !== 1'b1) begin nerr++; $display("FAIL wrap_sticky oerr got %b want 1", bus.order_error); end
        bus.out_ready = 1'b0;
        set_ch(0, 8'd7);
        set_ch(1, 8'd8);
        step();
        clear_in();
        nvec++; if (bus.count !== 4'd2) begin nerr++; $display("FAIL wrap_refill count got %0d want 2", bus.count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvec++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.order_error !== 1'b0) begin nerr++; $display("FAIL midreset count %0d valid %b oerr %b want 0 0 0", bus.count, bus.out_valid, bus.order_error); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clear_in();
            set_ch(0, 8'(20 + i));
            step();
            nvec++; if (bus.out_order !== 8'(20 + i) || bus.count !== 4'd1) begin nerr++; $display("FAIL b2b[%0d] order %0d count %0d want %0d 1", i, bus.out_order, bus.count, 20 + i); end
        end
        clear_in();
        step();
        nvec++; if (bus.count !== 4'd0 || bus.order_error !== 1'b0 || bus.overflow !== 1'b0) begin nerr++; $display("FAIL b2b_end count %0d oerr %b ovf %b want 0 0 0", bus.count, bus.order_error, bus.overflow); end
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        clear_in();
        test_reset();
        test_single_push();
        test_dual_retire();
        test_gap_compaction();
        test_overflow();
        test_pop_at_full();
        test_order_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", nvec);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rvfi_retire_serializer.md
Name: rvfi_retire_serializer

Overview:
- Upstream feeder for single-channel RVFI consumers such as the register-consistency check.
- Accepts an NRET-wide RVFI retire bundle and buffers the valid channels in a FIFO.
- Emits them one per cycle on a single RVFI channel, oldest first, with ready/valid output.
- Flags FIFO overflow and out-of-sequence rvfi_order values.

Parameters:
- NRET, 2, number of input retire channels (1..4).
- XLEN, 32, data width of pc/rs/rd fields.
- DEPTH, 8, FIFO entries; must be a power of 2 and >= NRET.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NRET  per-channel retire valid.
- in_order  in  NRET*8  per-channel rvfi_order.
- in_insn  in  NRET*32  instruction word.
- in_trap  in  NRET  trap flag.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  NRET*5  register addresses.
- in_rs1_rdata, in_rs2_rdata, in_rd_wdata  in  NRET*XLEN  register data.
- in_pc_rdata, in_pc_wdata  in  NRET*XLEN  pc before/after.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_order, out_insn, out_trap, out_rs1_addr, out_rs2_addr, out_rd_addr, out_rs1_rdata, out_rs2_rdata, out_rd_wdata, out_pc_rdata, out_pc_wdata  out  single-channel widths  head entry fields.
- overflow  out  1  sticky: an input cycle was dropped.
- order_error  out  1  sticky: out_order broke the +1 sequence.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high): wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, overflow = 0, order_error = 0, expect_valid = 0. Output data fields are don't-care while out_valid = 0.
- Push: within one cycle, channels with in_valid set are written in ascending channel index; index 0 is oldest. Writes are compacted, so gaps in in_valid leave no holes.
- Pop: when out_valid && out_ready, the head entry is removed at the clock edge.
- Latency: an entry pushed at edge N is visible on out_* after edge N if the FIFO was empty, i.e. one cycle. There is no combinational in->out path.
- Capacity check: npush = popcount(in_valid), pop = out_valid && out_ready. Accept the push iff count - pop + npush <= DEPTH; a same-cycle pop frees space.
- If the check fails: the whole cycle's pushes are dropped (no partial write), overflow sets and stays set until reset, and the pop still proceeds.
- count updates as count + npush_accepted - pop. Pointers wrap modulo DEPTH.
- out_valid = (count != 0), registered-state based. Fields come from the entry at rd_ptr.
- Order check, evaluated on each pop:
  - If expect_valid and out_order != expect_order, set order_error (sticky).
  - On every pop, expect_order <= out_order + 1 (8-bit wrap, 255 -> 0) and expect_valid <= 1.
  - The first pop after reset seeds the sequence and is never an error.
- Full FIFO with out_ready = 0 and npush >= 1: overflow sets and count stays at DEPTH.
- Empty FIFO: out_ready is ignored and no pop occurs.
- Reset asserted mid-stream discards all entries. Input presented in the reset cycle is not captured.

Optional Feature:
- Macro: RVFI_RETIRE_SERIALIZER_MEM_EN.
- Defined: adds the memory fields, carried through the FIFO identically to the other fields.
  - Inputs: in_mem_addr (NRET*XLEN), in_mem_rmask (NRET*XLEN/8), in_mem_wmask (NRET*XLEN/8), in_mem_rdata (NRET*XLEN), in_mem_wdata (NRET*XLEN).
  - Outputs: the matching single-channel out_mem_* ports.
- Undefined: none of these ports exist and FIFO entry width shrinks accordingly. All other behaviour is identical.

Test Plan:
- Single push: reset, then in_valid = 2'b01, order = 5, out_ready = 1 -> out_valid = 1 one cycle later with out_order = 5; count returns to 0 the cycle after; no flags.
- Dual retire: in_valid = 2'b11, orders 10 (ch0) and 11 (ch1), out_ready = 1 -> out_order 10 then 11 on consecutive cycles; order_error = 0.
- Gap compaction: in_valid = 2'b10 with order 3 -> exactly one entry with order 3; count = 1.
- Overflow: DEPTH = 8, out_ready = 0, four cycles of 2'b11 fill to 8. A fifth 2'b11 -> overflow = 1, count = 8, and the drained sequence holds only the first 8 orders.
- Simultaneous pop at full: count = 8, out_ready = 1, in_valid = 2'b01 -> push accepted, count stays 8, overflow stays 0.
- Order error and wrap: pops of 254, 255, 0 -> no error; next pop of 2 (expecting 1) -> order_error = 1 and stays set. Then reset mid-stream -> count = 0, out_valid = 0, order_error = 0.
